// File: rtl/co_co_mixer_pkg.sv
// Shared definitions for the complex mixer: default word size, phase state
// encoding and the rounding bias derived from the word size.
package mixer_pkg;

  localparam int DSZ_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    PH0,
    PH1,
    PH2,
    PH3
  } phase_e;

  // Half an LSB of the output word, expressed in product units.
  function automatic int rnd_const(input int dsz);
    return 1 << (dsz - 2);
  endfunction

endpackage

// File: rtl/co_co_mixer_if.sv
// Sample handshake and result bus of the complex mixer.
interface co_co_mixer_if #(
  parameter int DSZ = mixer_pkg::DSZ_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DSZ-1:0] in_i;
  logic signed [DSZ-1:0] in_q;
  logic signed [DSZ-1:0] lo_i;
  logic signed [DSZ-1:0] lo_q;
  logic                  conj;
  logic                  out_valid;
  logic signed [DSZ-1:0] out_i;
  logic signed [DSZ-1:0] out_q;

  modport master (
    output in_valid, in_i, in_q, lo_i, lo_q, conj,
    input  in_ready, out_valid, out_i, out_q
  );

  modport slave (
    input  in_valid, in_i, in_q, lo_i, lo_q, conj,
    output in_ready, out_valid, out_i, out_q
  );
endinterface

// File: rtl/co_co_mixer_saturator.sv
// Signed saturator: clamps an ISZ-bit value into the OSZ-bit two's-complement range.
module saturator #(
  parameter int ISZ = 18,
  parameter int OSZ = 16
) (
  input  logic signed [ISZ-1:0] din,
  output logic signed [OSZ-1:0] dout
);
  localparam logic signed [ISZ-1:0] MAXV = {{(ISZ-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [ISZ-1:0] MINV = {{(ISZ-OSZ+1){1'b1}}, {(OSZ-1){1'b0}}};

  always_comb begin
    dout = din[OSZ-1:0];
    if (din > MAXV)      dout = MAXV[OSZ-1:0];
    else if (din < MINV) dout = MINV[OSZ-1:0];
  end
endmodule

// File: rtl/co_co_mixer.sv
// Complex x complex mixer sharing one multiplier over four phases.
// Define CO_CO_MIXER_CONJ_EN to enable multiplication by the conjugate LO via the conj input.
module co_co_mixer
  import mixer_pkg::*;
#(
  parameter int DSZ = DSZ_DEF
) (
  input logic         clk,
  input logic         reset_n,
  co_co_mixer_if.slave bus
);
  localparam int PW = 2 * DSZ;
  localparam int AW = 2 * DSZ + 1;
  localparam int RW = DSZ + 2;

  phase_e                state_q, state_d;
  logic signed [DSZ-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic                  conj_q, conj_d;
  logic signed [PW-1:0]  mul_q, mul_d;
  logic [1:0]            mph_q, mph_d;
  logic                  mconj_q, mconj_d, mvld_q, mvld_d;
  logic signed [AW-1:0]  acc_q, acc_d, isum_q, isum_d;
  logic [1:0]            aph_q, aph_d;
  logic                  avld_q, avld_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [DSZ-1:0] out_i_q, out_i_d, out_q_q, out_q_d;

  logic                  accept, done;
  logic signed [DSZ-1:0] op_x, op_y;
  logic signed [AW-1:0]  prod;
  logic signed [RW-1:0]  rnd_i, rnd_q;
  logic signed [DSZ-1:0] sat_i, sat_q;

  function automatic logic signed [RW-1:0] round_acc(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v + AW'(rnd_const(DSZ));
    return RW'(s >>> (DSZ - 1));
  endfunction

  assign bus.in_ready  = (state_q == IDLE) || (state_q == PH3);
  assign accept        = bus.in_valid && bus.in_ready;
  assign prod          = AW'(mul_q);
  assign rnd_i         = round_acc(isum_q);
  assign rnd_q         = round_acc(acc_q);
  assign done          = avld_q && (aph_q == 2'd3);
  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;

  saturator #(.ISZ(RW), .OSZ(DSZ)) u_sat_i (.din(rnd_i), .dout(sat_i));
  saturator #(.ISZ(RW), .OSZ(DSZ)) u_sat_q (.din(rnd_q), .dout(sat_q));

  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    conj_d = conj_q;
    case (state_q)
      IDLE:    if (accept) state_d = PH0;
      PH0:     state_d = PH1;
      PH1:     state_d = PH2;
      PH2:     state_d = PH3;
      PH3:     state_d = accept ? PH0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d = bus.in_i; b_d = bus.in_q; c_d = bus.lo_i; d_d = bus.lo_q;
`ifdef CO_CO_MIXER_CONJ_EN
      conj_d = bus.conj;
`else
      conj_d = 1'b0;
`endif
    end

    // Multiplier stage: one product per phase, tagged with phase and mode
    op_x = a_q; op_y = c_q; mvld_d = 1'b1; mph_d = 2'd0;
    case (state_q)
      PH0:     begin op_x = a_q; op_y = c_q; mph_d = 2'd0; end
      PH1:     begin op_x = b_q; op_y = d_q; mph_d = 2'd1; end
      PH2:     begin op_x = a_q; op_y = d_q; mph_d = 2'd2; end
      PH3:     begin op_x = b_q; op_y = c_q; mph_d = 2'd3; end
      default: mvld_d = 1'b0;
    endcase
    mul_d   = mvld_d ? PW'(op_x) * PW'(op_y) : mul_q;
    mconj_d = mvld_d ? conj_q : mconj_q;

    // Accumulator stage: I completes after P1, Q after P3
    avld_d = mvld_q; aph_d = mph_q; acc_d = acc_q; isum_d = isum_q;
    if (mvld_q) begin
      case (mph_q)
        2'd0:    acc_d = prod;
        2'd1:    acc_d = mconj_q ? acc_q + prod : acc_q - prod;
        2'd2:    acc_d = mconj_q ? -prod : prod;
        default: acc_d = acc_q + prod;
      endcase
    end
    if (avld_q && aph_q == 2'd1) isum_d = acc_q;

    // Output stage: round, saturate, pulse valid
    out_valid_d = done;
    out_i_d     = done ? sat_i : out_i_q;
    out_q_d     = done ? sat_q : out_q_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; conj_q <= 1'b0;
      mul_q <= '0; mph_q <= '0; mconj_q <= 1'b0; mvld_q <= 1'b0;
      acc_q <= '0; isum_q <= '0; aph_q <= '0; avld_q <= 1'b0;
      out_valid_q <= 1'b0; out_i_q <= '0; out_q_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; conj_q <= conj_d;
      mul_q <= mul_d; mph_q <= mph_d; mconj_q <= mconj_d; mvld_q <= mvld_d;
      acc_q <= acc_d; isum_q <= isum_d; aph_q <= aph_d; avld_q <= avld_d;
      out_valid_q <= out_valid_d; out_i_q <= out_i_d; out_q_q <= out_q_d;
    end
  end
endmodule
